multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle ARM control FSM that sequences the shared datapath. The datapath has one memory, one ALU, and an instruction register (IR). The block sits beside the datapath and takes the decoded IR fields and the live ALU flags. Each instruction runs in 3–5 cycles: it issues per-cycle enables and mux selects, and holds the architectural NZCV flag register. It also evaluates ARM condition codes once per instruction and gates every architectural write with the result.

## Interface
Parameters: none.

- clk  input  1  rising-edge clock (the block's single clock).
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- Cond  input  4  IR[31:28], condition field.
- Op  input  2  IR[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  input  6  IR[25:20]: [5]=I, [4:1]=cmd, [0]=S (memory: [0]=L, [5]=I; branch: [4]=L).
- Rd  input  4  IR[15:12], destination register.
- ALUFlags  input  4  live ALU NZCV, {N,Z,C,V}.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address mux: 0 = PC, 1 = ALU result register.
- MemWrite  output  1  data memory write.
- IRWrite  output  1  IR enable.
- RegWrite  output  1  register file write.
- ResultSrc  output  2  result mux: 00 = ALUOut register, 01 = memory data register, 10 = ALU direct.
- ALUSrcA  output  1  ALU A input: 0 = register A, 1 = PC.
- ALUSrcB  output  2  ALU B input: 00 = register B, 01 = ExtImm, 10 = constant 4.
- ALUControl  output  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ImmSrc  output  2  00 = imm8, 01 = imm12, 10 = imm24 branch offset; equals Op in all states.
- RegSrc  output  2  [0] = 1: Rn read port is R15; [1] = 1: Rm read port is Rd (for STR).
- Flags  output  4  current NZCV register.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. All unlisted outputs are 0 in each state.
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1. Next state is DECODE.
- **DECODE:**
  - ALUSrcA=1, ALUSrcB=10, ALUControl=00 (computes PC+8).
  - RegSrc = {Op==01 & ~Funct[0], Op==10}.
  - Latch cond_ex_q.
  - Next state: Op=01 → MEMADR; Op=00 & I → EXECI; Op=00 & ~I → EXECR; Op=10 → BRANCH; Op=11 → FETCH (NOP).
- **MEMADR:** ALUSrcB=01, ALUControl=00. Next state: L → MEMRD, ~L → MEMWR.
- **MEMRD:** AdrSrc=1. Next state is MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=cond_ex_q, PCWrite=cond_ex_q & (Rd==15). Next state is FETCH.
- **MEMWR:** AdrSrc=1, MemWrite=cond_ex_q. Next state is FETCH.
- **EXECR / EXECI:**
  - ALUSrcB=00 in EXECR, 01 in EXECI.
  - ALUControl from cmd: 0100 → 00, 0010 → 01, 1010 (CMP) → 01, 0000 → 10, 1100 → 11, other → 00.
  - Next state: ALUWB, except CMP → FETCH.
- **ALUWB:** ResultSrc=00, RegWrite=cond_ex_q, PCWrite=cond_ex_q & (Rd==15). Next state is FETCH.
- **BRANCH:**
  - ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=cond_ex_q.
  - BL also asserts RegWrite=cond_ex_q (datapath routes to R14).
  - Next state is FETCH.
- **Condition codes:**

  | Cond | Mnemonic | Passes when |
  |---|---|---|
  | 0000 | EQ | Z |
  | 0001 | NE | !Z |
  | 0010 | CS | C |
  | 0011 | CC | !C |
  | 0100 | MI | N |
  | 0101 | PL | !N |
  | 0110 | VS | V |
  | 0111 | VC | !V |
  | 1000 | HI | C & !Z |
  | 1001 | LS | !C \| Z |
  | 1010 | GE | N==V |
  | 1011 | LT | N!=V |
  | 1100 | GT | !Z & N==V |
  | 1101 | LE | Z \| N!=V |
  | 1110 | AL | 1 |
  | 1111 | never | 0 |

  The condition is evaluated against the Flags register, not ALUFlags.
- **Flag update:** at the clock edge ending EXECR/EXECI, Flags <= ALUFlags when cond_ex_q & (S | cmd==1010). For ADD/SUB/CMP all four flags load; for AND/ORR only N and Z load, while C and V hold.
- **Failed condition:** the instruction still walks its full state path. Only RegWrite, MemWrite, the branch/R15 PCWrite and the flag update are suppressed. The FETCH PCWrite is never gated.

## Timing
- **Reset (reset=0):** state → FETCH, Flags → 0000, cond_ex_q → 0, all outputs forced to 0 asynchronously. On the first rising edge after deassertion the block is in FETCH with FETCH outputs.
- **Reset mid-instruction:** abandons the instruction; no partial write is issued after reset asserts.
- **Latency in cycles (FETCH to next FETCH):**
  - data-processing: 4
  - CMP: 3
  - LDR: 5
  - STR: 4
  - B/BL: 3
  - Op=11: 2
- cond_ex_q is sampled in DECODE only. A flag update inside the same instruction does not affect that instruction's writeback.
- Outputs are a Moore decode of state plus cond_ex_q and registered IR fields. There is no combinational path from ALUFlags to outputs.

## Test plan
- **Reset and first fetch:** hold reset=0, then release → Flags=0000 and all outputs 0 during reset; first cycle after release has PCWrite=1, IRWrite=1, ALUSrcB=10.
- **ADDS R1 with S set:** Cond=1110, Op=00, Funct=101001, ALUFlags=0110 in EXECI → 4-cycle path FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in ALUWB; Flags=0110.
- **Conditional sequence:**
  - CMP with ALUFlags=0100 in EXECR → Flags=0100, 3 cycles, no RegWrite.
  - Then BEQ → PCWrite=1 in BRANCH.
  - Then BNE → PCWrite=0 in BRANCH.
- **LDR to R15:** Cond=1110, Op=01, Funct=011001, Rd=15 → states MEMADR, MEMRD, MEMWB; MEMWB has ResultSrc=01, RegWrite=1, PCWrite=1.
- **Failed STR, then undefined Op:** STRNE with Z=1 → MemWrite stays 0 through MEMWR. Op=11 → returns to FETCH after DECODE with no writes.
- **Reset during MEMRD:** reset drops → outputs 0 immediately; after release the next cycle is FETCH and no MemWrite/RegWrite occurs.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: ARM multicycle control FSM sequencing the shared datapath,
// with condition-code evaluation and the architectural NZCV flag register.
`default_nettype none

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state, state_next;
  logic       cond_ex_q;
  logic       cond_ex;
  logic [3:0] flags_q;
  logic [3:0] cmd;
  logic       is_cmp;
  logic [1:0] dp_alu;
  logic       in_exec;
  logic       rd_is_pc;

  assign cmd      = Funct[4:1];
  assign is_cmp   = (cmd == 4'b1010);
  assign in_exec  = (state == EXECR) || (state == EXECI);
  assign rd_is_pc = (Rd == 4'd15);

  always_comb begin
    dp_alu = 2'b00;
    case (cmd)
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b1010: dp_alu = 2'b01;
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      default: dp_alu = 2'b00;
    endcase
  end

  // Evaluated against the architectural flags; {N,Z,C,V} = flags_q[3:0].
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      cond_ex_q <= 1'b0;
      flags_q   <= 4'b0000;
    end else begin
      state <= state_next;
      if (state == DECODE)
        cond_ex_q <= cond_ex;
      // Logical ops (AND/ORR) carry no meaningful C/V, so those hold.
      if (in_exec && cond_ex_q && (Funct[0] || is_cmp)) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (!dp_alu[1])
          flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_next = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ImmSrc     = Op;
    RegSrc     = 2'b00;
    Flags      = flags_q;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        RegSrc  = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex_q;
        PCWrite   = cond_ex_q & rd_is_pc;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
        ALUControl = dp_alu;
        state_next = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        RegWrite = cond_ex_q;
        PCWrite  = cond_ex_q & rd_is_pc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex_q;
        RegWrite  = cond_ex_q & Funct[4];
      end
      default: state_next = FETCH;
    endcase
    // Reset blanks every control line immediately, independent of the clock.
    if (!reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench; per-cycle expected control vectors are
// queued when an instruction is issued and compared at each falling edge.
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Flags(Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [19:0] vec;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  flags_m = 4'b0000;
  logic [1:0]  cur_op = 2'b00;
  logic [19:0] obs;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {12'b0, obs}, {12'b0, e.vec});
    end
  end

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [19:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] res,
                                     input logic sa, input logic [1:0] sbsel,
                                     input logic [1:0] aluc, input logic [1:0] rs);
    return {pcw, adr, mw, irw, rw, res, sa, sbsel, aluc, cur_op, rs, flags_m};
  endfunction

  task automatic push(input string tag, input logic [19:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    sb.push_back(e);
  endtask

  // Called at the start of a FETCH cycle; queues the whole expected trace, then waits it out.
  task automatic issue(input string name, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r, input logic [3:0] af);
    int n;
    logic pass, wpc;
    logic [1:0] ac;
    n = 0;
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af; cur_op = o;
    pass = cond_ok(c, flags_m);
    wpc  = pass && (r == 4'd15);
    push({name, ".FETCH"}, mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00)); n++;
    push({name, ".DECODE"}, mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00,
                               {(o == 2'b01) && !f[0], o == 2'b10})); n++;
    case (o)
      2'b01: begin
        push({name, ".MEMADR"}, mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00)); n++;
        if (f[0]) begin
          push({name, ".MEMRD"}, mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00)); n++;
          push({name, ".MEMWB"}, mk(wpc, 0, 0, 0, pass, 2'b01, 0, 2'b00, 2'b00, 2'b00)); n++;
        end else begin
          push({name, ".MEMWR"}, mk(0, 1, pass, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00)); n++;
        end
      end
      2'b00: begin
        case (f[4:1])
          4'b0010, 4'b1010: ac = 2'b01;
          4'b0000:          ac = 2'b10;
          4'b1100:          ac = 2'b11;
          default:          ac = 2'b00;
        endcase
        push({name, f[5] ? ".EXECI" : ".EXECR"},
             mk(0, 0, 0, 0, 0, 2'b00, 0, f[5] ? 2'b01 : 2'b00, ac, 2'b00)); n++;
        if (pass && (f[0] || f[4:1] == 4'b1010))
          flags_m = ac[1] ? {af[3:2], flags_m[1:0]} : af;
        if (f[4:1] != 4'b1010) begin
          push({name, ".ALUWB"}, mk(wpc, 0, 0, 0, pass, 2'b00, 0, 2'b00, 2'b00, 2'b00)); n++;
        end
      end
      2'b10: begin
        push({name, ".BRANCH"}, mk(pass, 0, 0, 0, pass && f[4], 2'b10, 0, 2'b01, 2'b00, 2'b00)); n++;
      end
      default: ;
    endcase
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; Cond = 4'hE; Op = 2'b10; Funct = 6'b010001; Rd = 4'd15; ALUFlags = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {12'b0, obs}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    issue("ADDS_I", 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0110);
    check("adds_flags", {28'b0, Flags}, 32'h6);
    issue("CMP", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
    check("cmp_flags", {28'b0, Flags}, 32'h4);
    issue("BEQ", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    issue("BNE", 4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
    issue("LDR_PC", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    issue("STRNE", 4'h1, 2'b01, 6'b011000, 4'd2, 4'b0000);
    issue("UNDEF", 4'hE, 2'b11, 6'b111111, 4'd15, 4'b1111);
    issue("SUBS", 4'hE, 2'b00, 6'b000101, 4'd3, 4'b0011);
    issue("ANDS", 4'hE, 2'b00, 6'b100001, 4'd4, 4'b1100);
    check("ands_keeps_cv", {28'b0, Flags}, 32'hF);
    issue("ORR_noS", 4'hE, 2'b00, 6'b011000, 4'd5, 4'b0000);
    issue("BLGE", 4'hA, 2'b10, 6'b010000, 4'd0, 4'b0000);
    issue("ADD_PC", 4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000);
    issue("ADDS_NV", 4'hF, 2'b00, 6'b101001, 4'd15, 4'b0000);
    issue("STR", 4'hE, 2'b01, 6'b011000, 4'd6, 4'b0000);
    for (int i = 0; i < 30; i++)
      issue("RND", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Abandon an LDR while it sits in MEMRD.
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd15; ALUFlags = 4'h0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("reset_mid_async", {12'b0, obs}, 32'd0);
    @(negedge clk);
    check("reset_mid_held", {12'b0, obs}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    flags_m = 4'b0000;
    issue("POST_RST", 4'hE, 2'b00, 6'b001001, 4'd7, 4'b1000);
    check("sb_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
